// File: rtl/rom_pkg.sv
// Shared constants and FSM state encoding for the 8x8 ROM and its burst reader.
package rom_pkg;

  localparam int ROM_ADDR_W = 3;
  localparam int ROM_DATA_W = 8;
  localparam int ROM_LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } rom_state_e;

endpackage

// File: rtl/rom_burst_reader.sv
// Burst sequencer in front of the combinational 8x8 ROM; streams words out on valid/ready.
// Optional ROM_BURST_CHECKSUM_EN adds checksum_o, the modulo sum of the beats in the burst.
module rom_burst_reader
  import rom_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = ROM_DATA_W,
  parameter int LEN_W  = ROM_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              rom_cs_o,
  output logic              rom_rd_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic              done_o
`ifdef ROM_BURST_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum_o
`endif
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(2 ** ADDR_W);

  rom_state_e        state_r;
  rom_state_e        state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  rem_r;
  logic [LEN_W-1:0]  len_clamped_s;
  logic [DATA_W-1:0] data_r;

  assign len_clamped_s = (len_i > LEN_MAX) ? LEN_MAX : len_i;

  // Next-state decode for the burst FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i == {LEN_W{1'b0}}) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: state_nxt_s = ST_HOLD;
      ST_HOLD: begin
        if (m_ready_i) begin
          if (rem_r == LEN_W'(1)) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_FETCH;
          end
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, address/count and captured-data registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      rem_r   <= {LEN_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            addr_r <= start_addr_i;
            rem_r  <= len_clamped_s;
          end
        end
        // ROM bus is only driven in FETCH, so this is the only place it is sampled.
        ST_FETCH: data_r <= rom_data_i;
        ST_HOLD: begin
          if (m_ready_i) begin
            rem_r  <= rem_r - LEN_W'(1);
            addr_r <= addr_r + ADDR_W'(1);
          end
        end
        ST_DONE: ;
        default: ;
      endcase
    end
  end

`ifdef ROM_BURST_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;

  // Running sum of handshaken beats, cleared when a burst is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_IDLE) && start_i) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if ((state_r == ST_HOLD) && m_ready_i) begin
      checksum_r <= checksum_r + data_r;
    end
  end

  assign checksum_o = checksum_r;
`endif

  assign busy_o      = (state_r != ST_IDLE);
  assign rom_cs_o    = (state_r == ST_FETCH);
  assign rom_rd_en_o = (state_r == ST_FETCH);
  assign rom_addr_o  = addr_r;
  assign m_valid_o   = (state_r == ST_HOLD);
  assign m_data_o    = data_r;
  assign done_o      = (state_r == ST_DONE);

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed, table-driven bench for rom_burst_reader with an inline 8x8 ROM load.
module tb_rom_burst_reader;

  localparam logic [7:0] ROM_C [8] = '{8'd21, 8'd255, 8'd33, 8'd99, 8'd127, 8'd13, 8'd10, 8'd88};

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] len;
  logic       busy;
  logic       rom_cs;
  logic       rom_rd_en;
  logic [2:0] rom_addr;
  wire  [7:0] rom_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       done;
`ifdef ROM_BURST_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checks;
  int failures;

  assign rom_data = (rom_cs && rom_rd_en) ? ROM_C[rom_addr] : 8'hzz;

  rom_burst_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .start_addr_i (start_addr),
    .len_i        (len),
    .busy_o       (busy),
    .rom_cs_o     (rom_cs),
    .rom_rd_en_o  (rom_rd_en),
    .rom_addr_o   (rom_addr),
    .rom_data_i   (rom_data),
    .m_valid_o    (m_valid),
    .m_data_o     (m_data),
    .m_ready_i    (m_ready),
    .done_o       (done)
`ifdef ROM_BURST_CHECKSUM_EN
    ,
    .checksum_o   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] addr;
    logic [3:0] len;
    int         stall;
    bit         restart;
    int         n;
    logic [7:0] beats [0:7];
    logic [7:0] sum;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic run_burst(input vec_t v);
    int  k;
    int  beat;
    int  cs_cnt;
    int  done_cnt;
    int  done_k;
    int  first_v;
    int  hold_cnt;
    bit  fin;
    beat = 0; cs_cnt = 0; done_cnt = 0; done_k = -1; first_v = -1; hold_cnt = 0; fin = 1'b0;
    start_addr = v.addr;
    len        = v.len;
    m_ready    = 1'b1;
    start      = 1'b1;
    tick();
    k = 1;
    while (!fin && k < 60) begin
      if (v.restart && k == 1) begin
        start = 1'b1; start_addr = 3'd0; len = 4'd3;
      end else begin
        start = 1'b0;
      end
      if (rom_cs) cs_cnt++;
      if (done) begin
        done_cnt++;
        done_k = k;
`ifdef ROM_BURST_CHECKSUM_EN
        check({v.name, " checksum"}, int'(checksum), int'(v.sum));
`endif
      end
      if (m_valid) begin
        if (first_v < 0) first_v = k;
        check({v.name, " cs_in_hold"}, int'(rom_cs), 0);
        if (beat < 8) check($sformatf("%s beat%0d", v.name, beat), int'(m_data), int'(v.beats[beat]));
        m_ready = !(beat == 0 && hold_cnt < v.stall);
        if (beat == 0) hold_cnt++;
        if (m_ready) beat++;
      end else begin
        m_ready = 1'b1;
      end
      if (!busy && !(v.restart && k == 1)) begin
        fin = 1'b1;
      end else begin
        tick();
        k++;
      end
    end
    start = 1'b0;
    check({v.name, " timeout"}, int'(fin), 1);
    check({v.name, " beat_count"}, beat, v.n);
    check({v.name, " done_pulses"}, done_cnt, 1);
    check({v.name, " cs_cycles"}, cs_cnt, v.n);
    if (v.n > 0) check({v.name, " first_valid_latency"}, first_v, 2);
    else         check({v.name, " done_latency"}, done_k, 1);
  endtask

  initial begin
    vec_t rv;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; start_addr = 3'd0; len = 4'd0; m_ready = 1'b0;

    vecs[0] = '{name: "t1_addr2_len3", addr: 3'd2, len: 4'd3, stall: 0, restart: 1'b0, n: 3,
                beats: '{8'd33, 8'd99, 8'd127, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, sum: 8'd3};
    vecs[1] = '{name: "t2_wrap", addr: 3'd6, len: 4'd4, stall: 0, restart: 1'b0, n: 4,
                beats: '{8'd10, 8'd88, 8'd21, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0}, sum: 8'd118};
    vecs[2] = '{name: "t3_stall", addr: 3'd1, len: 4'd2, stall: 5, restart: 1'b0, n: 2,
                beats: '{8'd255, 8'd33, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, sum: 8'd32};
    vecs[3] = '{name: "t4_len0_restart", addr: 3'd4, len: 4'd0, stall: 0, restart: 1'b1, n: 0,
                beats: '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, sum: 8'd0};
    vecs[4] = '{name: "t6_clamp", addr: 3'd3, len: 4'd9, stall: 0, restart: 1'b0, n: 8,
                beats: '{8'd99, 8'd127, 8'd13, 8'd10, 8'd88, 8'd21, 8'd255, 8'd33}, sum: 8'd134};

    tick();
    tick();
    check("reset busy", int'(busy), 0);
    check("reset cs", int'(rom_cs), 0);
    check("reset valid", int'(m_valid), 0);
    check("reset done", int'(done), 0);
    check("reset data", int'(m_data), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_burst(vecs[i]);
      tick();
    end

    // Reset while a len=5 burst sits in HOLD.
    start_addr = 3'd0; len = 4'd5; m_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t5 in_hold", int'(m_valid), 1);
    rst_n = 1'b0;
    tick();
    check("t5 busy", int'(busy), 0);
    check("t5 cs", int'(rom_cs), 0);
    check("t5 rd_en", int'(rom_rd_en), 0);
    check("t5 valid", int'(m_valid), 0);
    check("t5 done", int'(done), 0);
    check("t5 addr", int'(rom_addr), 0);
    check("t5 data", int'(m_data), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5 no_done", int'(done), 0);
    end
    rv = '{name: "t5_after_reset", addr: 3'd0, len: 4'd1, stall: 0, restart: 1'b0, n: 1,
           beats: '{8'd21, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, sum: 8'd21};
    run_burst(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
